// File: rtl/msg_tx_sequencer_pkg.sv
// Shared constants for the status-message path: message size, line terminators,
// sequencer state encoding and the gap-counter width helper.
package msg_tx_sequencer_pkg;

    localparam int         NCHAR_DEF = 6;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Width of a counter holding 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/msg_gap_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. in the
// last of load_val cycles after the load.
module msg_gap_timer
    import msg_tx_sequencer_pkg::*;
#(
    parameter int W = cnt_width(16)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/msg_tx_sequencer.sv
// Serialises the NCHAR-byte status message onto a valid/ready byte stream,
// snapshotting it on a send request or a content change, with a one-deep queue.
module msg_tx_sequencer
    import msg_tx_sequencer_pkg::*;
#(
    parameter int NCHAR     = NCHAR_DEF,
    parameter bit AUTO_SEND = 1'b1,
    parameter int GAP_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*NCHAR-1:0] message,
    input  logic               send_req,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               pending
);

    localparam int            MW       = 8 * NCHAR;
    localparam int            IW       = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam int            GW       = cnt_width(GAP_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHAR - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

    tx_state_e     state_q, state_d;
    logic [MW-1:0] buf_q, buf_d;
    logic [MW-1:0] last_sent_q, last_sent_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pending_q, pending_d;
    logic          trig;
    logic          gap_load;
    logic          gap_done;
    logic [7:0]    chars [NCHAR];

    // Char 0 lives in the top byte of the message and goes out first.
    for (genvar g = 0; g < NCHAR; g++) begin : g_chars
        assign chars[g] = buf_q[MW-1-8*g -: 8];
    end

    assign trig = send_req | (AUTO_SEND && (message != last_sent_q));

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        last_sent_d = last_sent_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        gap_load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A queued send reloads here, re-sampling the newest message.
                if (trig || pending_q) begin
                    buf_d       = message;
                    last_sent_d = message;
                    idx_d       = '0;
                    pending_d   = 1'b0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (trig) pending_d = 1'b1;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (GAP_CYC == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d  = ST_GAP;
                            gap_load = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (trig) pending_d = 1'b1;
                if (gap_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            last_sent_q <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            last_sent_q <= last_sent_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
        end
    end

    msg_gap_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .done     (gap_done)
    );

    assign tx_valid = (state_q == ST_SEND);
    assign tx_data  = tx_valid ? chars[idx_q] : 8'h00;
    assign busy     = (state_q != ST_IDLE);
    assign pending  = pending_q;

endmodule
